reg_scoreboard: RTL and testbench

- Issue-stage controller sequencing access to the 32x32 register file.
- Tracks in-flight destination writes per register with a small counter. Stalls decode on RAW hazards.
- Accounts for the register file's same-cycle write-to-read forwarding, so a writeback landing this cycle does not cause a stall.
- Sits between decode/issue and the register file write port.

---
 rtl/reg_scoreboard.sv | 124 ++++++++++++
 tb/tb_reg_scoreboard.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_scoreboard                                                |
// | Purpose  : Register-file issue scoreboard with RAW stall and writeback   |
// |            bypass. Define SCOREBOARD_WAW_STALL_EN to limit each register |
// |            to one in-flight write.                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module reg_scoreboard #(
    parameter int  NREGS     = 32,
    parameter int  IDXW      = 5,
    parameter int  CNTW      = 2,
    parameter int  MAX_TOTAL = 8,
    localparam int TOTW      = $clog2(MAX_TOTAL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [IDXW-1:0]  issue_rd,
    input  logic             issue_rwrite,
    input  logic [IDXW-1:0]  r1_idx,
    input  logic             r1_used,
    input  logic [IDXW-1:0]  r2_idx,
    input  logic             r2_used,
    input  logic             rwrite,
    input  logic [IDXW-1:0]  write_idx,
    input  logic             flush,
    output logic             stall,
    output logic             issue_ack,
    output logic [NREGS-1:0] busy_mask,
    output logic [TOTW-1:0]  pending_total,
    output logic             err_underflow
);

    localparam logic [CNTW-1:0] c_cnt_max   = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] c_cnt_one   = CNTW'(1);
    localparam logic [TOTW-1:0] c_total_max = TOTW'(MAX_TOTAL);

    logic [CNTW-1:0] r_cnt [NREGS];
    logic [TOTW-1:0] r_total;
    logic            r_err;

    logic [CNTW-1:0] w_cnt_s1, w_cnt_s2, w_cnt_rd, w_cnt_wb;
    logic            w_haz1, w_haz2, w_dest_full, w_total_full;
    logic            w_wb_valid, w_underflow, w_inc;

    assign w_cnt_s1 = r_cnt[r1_idx];
    assign w_cnt_s2 = r_cnt[r2_idx];
    assign w_cnt_rd = r_cnt[issue_rd];
    assign w_cnt_wb = r_cnt[write_idx];

    always_comb begin
        w_wb_valid  = rwrite && (write_idx != '0) && (w_cnt_wb != '0);
        w_underflow = rwrite && (write_idx != '0) && (w_cnt_wb == '0);

        // A writeback retiring the last pending write is forwarded by the file.
        w_haz1 = r1_used && (r1_idx != '0) && (w_cnt_s1 != '0) &&
                 !(rwrite && (write_idx == r1_idx) && (w_cnt_s1 == c_cnt_one));
        w_haz2 = r2_used && (r2_idx != '0) && (w_cnt_s2 != '0) &&
                 !(rwrite && (write_idx == r2_idx) && (w_cnt_s2 == c_cnt_one));

`ifdef SCOREBOARD_WAW_STALL_EN
        w_dest_full = issue_rwrite && (issue_rd != '0) && (w_cnt_rd != '0) &&
                      !(rwrite && (write_idx == issue_rd) && (w_cnt_rd == c_cnt_one));
`else
        w_dest_full = issue_rwrite && (issue_rd != '0) && (w_cnt_rd == c_cnt_max);
`endif

        w_total_full = issue_rwrite && (r_total == c_total_max) && !w_wb_valid;

        stall     = issue_valid && (w_haz1 || w_haz2 || w_dest_full || w_total_full);
        issue_ack = issue_valid && !stall;
        w_inc     = issue_ack && issue_rwrite && (issue_rd != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= '0;
            end
            r_total <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_underflow) begin
                r_err <= 1'b1;
            end
            if (flush) begin
                for (int i = 0; i < NREGS; i++) begin
                    r_cnt[i] <= '0;
                end
                r_total <= '0;
            end else begin
                // Entry 0 is never written after reset, so it stays zero.
                for (int i = 1; i < NREGS; i++) begin
                    if (w_inc && (issue_rd == IDXW'(i)) &&
                        !(w_wb_valid && (write_idx == IDXW'(i)))) begin
                        r_cnt[i] <= r_cnt[i] + c_cnt_one;
                    end else if (w_wb_valid && (write_idx == IDXW'(i)) &&
                                 !(w_inc && (issue_rd == IDXW'(i)))) begin
                        r_cnt[i] <= r_cnt[i] - c_cnt_one;
                    end
                end
                if (w_inc && !w_wb_valid) begin
                    r_total <= r_total + TOTW'(1);
                end else if (w_wb_valid && !w_inc) begin
                    r_total <= r_total - TOTW'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_mask[gi] = 1'b0;
        end else begin : g_reg
            assign busy_mask[gi] = (r_cnt[gi] != '0);
        end
    end

    assign pending_total = r_total;
    assign err_underflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_reg_scoreboard                                             |
// | Purpose  : Directed and randomized checks of reg_scoreboard against an   |
// |            integer reference model.                                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_reg_scoreboard;

    localparam int NREGS     = 32;
    localparam int IDXW      = 5;
    localparam int CNTW      = 2;
    localparam int MAX_TOTAL = 8;
    localparam int TOTW      = 4;
    localparam int CMAX      = (1 << CNTW) - 1;
`ifdef SCOREBOARD_WAW_STALL_EN
    localparam int SAT_LIMIT = 1;
`else
    localparam int SAT_LIMIT = CMAX;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid, issue_rwrite, r1_used, r2_used, rwrite, flush;
    logic [IDXW-1:0]  issue_rd, r1_idx, r2_idx, write_idx;
    logic             stall, issue_ack, err_underflow;
    logic [NREGS-1:0] busy_mask;
    logic [TOTW-1:0]  pending_total;

    reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rwrite(issue_rwrite),
        .r1_idx(r1_idx), .r1_used(r1_used), .r2_idx(r2_idx), .r2_used(r2_used),
        .rwrite(rwrite), .write_idx(write_idx), .flush(flush),
        .stall(stall), .issue_ack(issue_ack), .busy_mask(busy_mask),
        .pending_total(pending_total), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int m_cnt [NREGS];
    int m_total;
    bit m_err;
    int n_checks = 0;
    int n_pass   = 0;

    function automatic bit m_haz(int idx, bit used);
        return used && idx != 0 && m_cnt[idx] > 0 &&
               !(rwrite && int'(write_idx) == idx && m_cnt[idx] == 1);
    endfunction

    function automatic bit m_stall();
        int  rd;
        bit  dest_full, total_full;
        rd = int'(issue_rd);
        if (!issue_valid) return 1'b0;
`ifdef SCOREBOARD_WAW_STALL_EN
        dest_full = issue_rwrite && rd != 0 && m_cnt[rd] > 0 &&
                    !(rwrite && int'(write_idx) == rd && m_cnt[rd] == 1);
`else
        dest_full = issue_rwrite && rd != 0 && m_cnt[rd] == CMAX;
`endif
        total_full = issue_rwrite && m_total == MAX_TOTAL &&
                     !(rwrite && write_idx != 0 && m_cnt[int'(write_idx)] > 0);
        return m_haz(int'(r1_idx), r1_used) || m_haz(int'(r2_idx), r2_used) ||
               dest_full || total_full;
    endfunction

    function automatic logic [NREGS-1:0] m_busy();
        logic [NREGS-1:0] b;
        b = '0;
        for (int i = 1; i < NREGS; i++) b[i] = (m_cnt[i] > 0);
        return b;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
        m_total = 0;
    endtask

    task automatic m_commit();
        bit ack;
        int wi, rd;
        ack = issue_valid && !m_stall();
        wi  = int'(write_idx);
        rd  = int'(issue_rd);
        if (rwrite && wi != 0 && m_cnt[wi] == 0) m_err = 1'b1;
        if (flush) begin
            m_clear();
        end else begin
            if (rwrite && wi != 0 && m_cnt[wi] > 0) begin
                m_cnt[wi]--;
                m_total--;
            end
            if (ack && issue_rwrite && rd != 0) begin
                m_cnt[rd]++;
                m_total++;
            end
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rwrite = 0; issue_rd = '0;
        r1_idx = '0; r1_used = 0; r2_idx = '0; r2_used = 0;
        rwrite = 0; write_idx = '0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        m_commit();
        @(negedge clk);
        idle();
    endtask

    task automatic issue_write(int rd);
        idle();
        issue_valid = 1; issue_rwrite = 1; issue_rd = IDXW'(rd);
    endtask

    task automatic drain();
        for (int i = 1; i < NREGS; i++) begin
            while (m_cnt[i] > 0) begin
                rwrite = 1; write_idx = IDXW'(i);
                step();
            end
        end
    endtask

    task automatic test_reset();
        issue_valid = 1; r1_used = 1; r1_idx = 5; issue_rwrite = 1; issue_rd = 6;
        #1;
        n_checks++;
        if (busy_mask !== '0) $display("FAIL reset_busy got=%h exp=0", busy_mask);
        else n_pass++;
        n_checks++;
        if (pending_total !== '0) $display("FAIL reset_total got=%0d exp=0", pending_total);
        else n_pass++;
        n_checks++;
        if (err_underflow !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_underflow);
        else n_pass++;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall);
        else n_pass++;
        idle();
    endtask

    task automatic test_raw();
        issue_write(5);
        #1;
        n_checks++;
        if (issue_ack !== 1'b1) $display("FAIL raw_first_ack got=%b exp=1", issue_ack);
        else n_pass++;
        step();
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1; r1_idx = 5; r1_used = 1;
            #1;
            n_checks++;
            if (stall !== 1'b1) $display("FAIL raw_stall cyc=%0d got=%b exp=1", k, stall);
            else n_pass++;
            step();
        end
        issue_valid = 1; r1_idx = 5; r1_used = 1; rwrite = 1; write_idx = 5;
        #1;
        n_checks++;
        if (stall !== 1'b0 || issue_ack !== 1'b1)
            $display("FAIL raw_bypass got stall=%b ack=%b exp stall=0 ack=1", stall, issue_ack);
        else n_pass++;
        step();
        n_checks++;
        if (busy_mask[5] !== 1'b0 || pending_total !== '0)
            $display("FAIL raw_retired got busy5=%b total=%0d exp 0/0", busy_mask[5], pending_total);
        else n_pass++;
    endtask

    task automatic test_zero();
        issue_write(0);
        step();
        issue_valid = 1; r1_idx = 0; r1_used = 1; r2_idx = 0; r2_used = 1;
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL zero_stall got=%b exp=0", stall);
        else n_pass++;
        n_checks++;
        if (pending_total !== '0) $display("FAIL zero_total got=%0d exp=0", pending_total);
        else n_pass++;
        step();
        rwrite = 1; write_idx = 0;
        step();
        n_checks++;
        if (err_underflow !== 1'b0) $display("FAIL zero_err got=%b exp=0", err_underflow);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int k = 0; k <= SAT_LIMIT; k++) begin
            issue_write(7);
            #1;
            n_checks++;
            if (stall !== (k >= SAT_LIMIT))
                $display("FAIL sat_issue%0d got=%b exp=%b", k, stall, k >= SAT_LIMIT);
            else n_pass++;
            step();
        end
        n_checks++;
        if (pending_total !== TOTW'(SAT_LIMIT))
            $display("FAIL sat_total got=%0d exp=%0d", pending_total, SAT_LIMIT);
        else n_pass++;
        drain();
    endtask

    task automatic test_total();
        for (int r = 1; r <= MAX_TOTAL; r++) begin
            issue_write(r);
            step();
        end
        n_checks++;
        if (pending_total !== TOTW'(MAX_TOTAL))
            $display("FAIL total_full got=%0d exp=%0d", pending_total, MAX_TOTAL);
        else n_pass++;
        issue_write(20);
        #1;
        n_checks++;
        if (stall !== 1'b1) $display("FAIL total_ninth got=%b exp=1", stall);
        else n_pass++;
        rwrite = 1; write_idx = 3;
        #1;
        n_checks++;
        if (stall !== 1'b0 || issue_ack !== 1'b1)
            $display("FAIL total_bypass got stall=%b ack=%b exp 0/1", stall, issue_ack);
        else n_pass++;
        step();
        n_checks++;
        if (pending_total !== TOTW'(MAX_TOTAL) || busy_mask[3] !== 1'b0 || busy_mask[20] !== 1'b1)
            $display("FAIL total_swap got total=%0d b3=%b b20=%b exp 8/0/1",
                     pending_total, busy_mask[3], busy_mask[20]);
        else n_pass++;
        drain();
    endtask

    task automatic test_flush_underflow();
        for (int r = 10; r < 13; r++) begin
            issue_write(r);
            step();
        end
        n_checks++;
        if (pending_total !== TOTW'(3)) $display("FAIL flush_pre got=%0d exp=3", pending_total);
        else n_pass++;
        issue_write(9);
        flush = 1;
        step();
        n_checks++;
        if (pending_total !== '0 || busy_mask !== '0)
            $display("FAIL flush_clear got total=%0d busy=%h exp 0/0", pending_total, busy_mask);
        else n_pass++;
        rwrite = 1; write_idx = 9;
        step();
        n_checks++;
        if (err_underflow !== 1'b1) $display("FAIL underflow_set got=%b exp=1", err_underflow);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (err_underflow !== 1'b1) $display("FAIL underflow_sticky got=%b exp=1", err_underflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        issue_write(5); step();
        issue_write(5); step();
        n_checks++;
        if (pending_total !== TOTW'(2) || busy_mask[5] !== 1'b1)
            $display("FAIL rstmid_pre got total=%0d b5=%b exp 2/1", pending_total, busy_mask[5]);
        else n_pass++;
        #1 rst = 1;
        #1;
        n_checks++;
        if (pending_total !== '0 || busy_mask !== '0 || err_underflow !== 1'b0)
            $display("FAIL rstmid_async got total=%0d busy=%h err=%b exp 0/0/0",
                     pending_total, busy_mask, err_underflow);
        else n_pass++;
        m_clear();
        m_err = 1'b0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_random();
        int wi;
        for (int c = 0; c < 600; c++) begin
            idle();
            issue_valid  = ($urandom_range(0, 9) < 7);
            issue_rwrite = ($urandom_range(0, 3) != 0);
            issue_rd     = IDXW'($urandom_range(0, 11));
            r1_idx = IDXW'($urandom_range(0, 11)); r1_used = $urandom_range(0, 1);
            r2_idx = IDXW'($urandom_range(0, 11)); r2_used = $urandom_range(0, 1);
            if ($urandom_range(0, 49) == 0) begin
                flush = 1;
            end else if ($urandom_range(0, 9) < 6) begin
                wi = $urandom_range(0, 11);
                if ($urandom_range(0, 9) != 0) begin
                    for (int j = 0; j < 12; j++) begin
                        if (m_cnt[(wi + j) % 12] > 0) begin
                            wi = (wi + j) % 12;
                            break;
                        end
                    end
                end
                rwrite = 1; write_idx = IDXW'(wi);
            end
            #1;
            n_checks++;
            if (stall !== m_stall() || issue_ack !== (issue_valid && !m_stall()))
                $display("FAIL rand_comb cyc=%0d got stall=%b ack=%b exp stall=%b",
                         c, stall, issue_ack, m_stall());
            else n_pass++;
            step();
            n_checks++;
            if (busy_mask !== m_busy() || pending_total !== TOTW'(m_total) || err_underflow !== m_err)
                $display("FAIL rand_state cyc=%0d got busy=%h total=%0d err=%b exp busy=%h total=%0d err=%b",
                         c, busy_mask, pending_total, err_underflow, m_busy(), m_total, m_err);
            else n_pass++;
        end
    endtask

    initial begin
        idle();
        rst = 1;
        m_clear();
        m_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        test_reset();
        test_raw();
        test_zero();
        test_saturation();
        test_total();
        test_flush_underflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
